// File: rtl/pipe_stage_skid_reg.sv
// Flushable pipeline-stage register with a valid/ready handshake and a 2-entry skid buffer.
// Define PIPE_PERF_CNT_EN to build the saturating STALL_CNT / FLUSH_CNT counters.
module pipe_stage_skid_reg #(
  parameter int DATA_W = 160,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              BUSYWAIT,
  input  logic              FLUSH,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic [CTRL_W-1:0] IN_CTRL,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [CTRL_W-1:0] OUT_CTRL,
  output logic [CNT_W-1:0]  STALL_CNT,
  output logic [CNT_W-1:0]  FLUSH_CNT
);

  // State encoding is {main valid, skid valid}; 2'b01 is unreachable.
  localparam logic [1:0] S_EMPTY = 2'b00;
  localparam logic [1:0] S_FULL  = 2'b10;
  localparam logic [1:0] S_SKID  = 2'b11;

  logic              main_vld_q, main_vld_d;
  logic              skid_vld_q, skid_vld_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [1:0]        state;
  logic              in_fire;
  logic              out_fire;

  assign state    = {main_vld_q, skid_vld_q};
  // Ready depends only on held state and global stall, never on OUT_READY.
  assign IN_READY = ~skid_vld_q & ~BUSYWAIT & ~RESET;
  assign in_fire  = IN_VALID & IN_READY & ~FLUSH;
  assign out_fire = main_vld_q & OUT_READY & ~BUSYWAIT;

  always_comb begin
    main_vld_d  = main_vld_q;
    skid_vld_d  = skid_vld_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_ctrl_d = skid_ctrl_q;
    if (FLUSH) begin
      main_vld_d  = 1'b0;
      skid_vld_d  = 1'b0;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end else if (!BUSYWAIT) begin
      case (state)
        S_EMPTY: begin
          if (in_fire) begin
            main_vld_d  = 1'b1;
            main_data_d = IN_DATA;
            main_ctrl_d = IN_CTRL;
          end
        end
        S_FULL: begin
          if (in_fire && out_fire) begin
            main_data_d = IN_DATA;
            main_ctrl_d = IN_CTRL;
          end else if (in_fire) begin
            skid_vld_d  = 1'b1;
            skid_data_d = IN_DATA;
            skid_ctrl_d = IN_CTRL;
          end else if (out_fire) begin
            main_vld_d  = 1'b0;
            main_ctrl_d = '0;
          end
        end
        S_SKID: begin
          if (out_fire) begin
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
            skid_vld_d  = 1'b0;
            skid_ctrl_d = '0;
          end
        end
        default: begin
          main_vld_d  = 1'b0;
          skid_vld_d  = 1'b0;
          main_ctrl_d = '0;
          skid_ctrl_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      main_vld_q  <= 1'b0;
      skid_vld_q  <= 1'b0;
      main_data_q <= '0;
      skid_data_q <= '0;
      main_ctrl_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      main_vld_q  <= main_vld_d;
      skid_vld_q  <= skid_vld_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

  assign OUT_VALID = main_vld_q;
  assign OUT_DATA  = main_data_q;
  assign OUT_CTRL  = main_ctrl_q & {CTRL_W{main_vld_q}};

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Both counters saturate at all-ones instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (main_vld_q && !out_fire && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (FLUSH && (main_vld_q || skid_vld_q) && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign STALL_CNT = stall_cnt_q;
  assign FLUSH_CNT = flush_cnt_q;
`else
  assign STALL_CNT = '0;
  assign FLUSH_CNT = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Scoreboard bench for pipe_stage_skid_reg: directed scenarios followed by randomized traffic.
module tb_pipe_stage_skid_reg;
  localparam int DATA_W = 32;
  localparam int CTRL_W = 16;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              CLK;
  logic              RESET;
  logic              BUSYWAIT;
  logic              FLUSH;
  logic              IN_VALID;
  logic              IN_READY;
  logic [DATA_W-1:0] IN_DATA;
  logic [CTRL_W-1:0] IN_CTRL;
  logic              OUT_VALID;
  logic              OUT_READY;
  logic [DATA_W-1:0] OUT_DATA;
  logic [CTRL_W-1:0] OUT_CTRL;
  logic [CNT_W-1:0]  STALL_CNT;
  logic [CNT_W-1:0]  FLUSH_CNT;

  pipe_stage_skid_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET(RESET), .BUSYWAIT(BUSYWAIT), .FLUSH(FLUSH),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA), .IN_CTRL(IN_CTRL),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA), .OUT_CTRL(OUT_CTRL),
    .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: the stage is a FIFO of at most two entries, oldest at index 0.
  logic [DATA_W+CTRL_W-1:0] sb[$];
  int tests = 0;
  int fails = 0;
  int stall_m = 0;
  int flush_m = 0;
  bit seen_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares outputs with the model, then applies the coming edge's effect.
  always @(negedge CLK) begin
    if (RESET) begin
      sb.delete();
      stall_m = 0;
      flush_m = 0;
    end
    check("in_ready", IN_READY, 64'(!RESET && !BUSYWAIT && sb.size() < 2));
    check("out_valid", OUT_VALID, 64'(sb.size() != 0));
    if (sb.size() != 0) begin
      check("out_data", OUT_DATA, 64'(sb[0][DATA_W+CTRL_W-1:CTRL_W]));
      check("out_ctrl", OUT_CTRL, 64'(sb[0][CTRL_W-1:0]));
    end else begin
      check("bubble_ctrl", OUT_CTRL, 64'd0);
    end
    if (OUT_VALID && OUT_DATA == 32'hABCDE123) seen_bad = 1'b1;
`ifdef PIPE_PERF_CNT_EN
    check("stall_cnt", STALL_CNT, 64'(stall_m));
    check("flush_cnt", FLUSH_CNT, 64'(flush_m));
`else
    check("stall_cnt_off", STALL_CNT, 64'd0);
    check("flush_cnt_off", FLUSH_CNT, 64'd0);
`endif
    if (!RESET) begin
      if (sb.size() != 0 && !(OUT_READY && !BUSYWAIT) && stall_m < CMAX) stall_m++;
      if (FLUSH) begin
        if (sb.size() != 0 && flush_m < CMAX) flush_m++;
        sb.delete();
      end else if (sb.size() != 0 && OUT_READY && !BUSYWAIT) begin
        void'(sb.pop_front());
      end
    end
  end

  // One clock of stimulus; an accepted entry is pushed once the monitor has retired the oldest.
  task automatic cycle(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                       input logic ordy, input logic bw, input logic fl);
    logic acc;
    @(posedge CLK);
    #1;
    IN_VALID  = v;
    IN_DATA   = d;
    IN_CTRL   = c;
    OUT_READY = ordy;
    BUSYWAIT  = bw;
    FLUSH     = fl;
    acc = v && !fl && !bw && !RESET && (sb.size() < 2);
    @(negedge CLK);
    #1;
    if (acc) sb.push_back({d, c});
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    IN_VALID = 1'b0;
    FLUSH = 1'b0;
    BUSYWAIT = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
  endtask

  function automatic logic [CTRL_W-1:0] rc();
    return CTRL_W'($urandom) | 16'h0001;
  endfunction

  initial begin
    RESET = 1'b0; BUSYWAIT = 1'b0; FLUSH = 1'b0; IN_VALID = 1'b0;
    IN_DATA = '0; IN_CTRL = '0; OUT_READY = 1'b0;
    #1 RESET = 1'b1;
    #2;
    check("rst_out_valid", OUT_VALID, 64'd0);
    check("rst_in_ready", IN_READY, 64'd0);
    check("rst_out_ctrl", OUT_CTRL, 64'd0);
    check("rst_stall_cnt", STALL_CNT, 64'd0);
    @(posedge CLK);
    @(posedge CLK);
    #1 RESET = 1'b0;

    // Streaming 1,2,3
    cycle(1'b1, 32'd1, rc(), 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'd2, rc(), 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'd3, rc(), 1'b1, 1'b0, 1'b0);
    repeat (2) cycle(1'b0, 32'd0, '0, 1'b1, 1'b0, 1'b0);

    // Back-pressure: A to main, B to skid, C refused until space frees up
    cycle(1'b1, 32'h12345678, rc(), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h87654321, rc(), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h0000CCCC, 16'h00C0, 1'b0, 1'b0, 1'b0);
    check("skid_in_ready", IN_READY, 64'd0);
    cycle(1'b1, 32'h0000CCCC, 16'h00C0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'h0000CCCC, 16'h00C0, 1'b1, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 32'd0, '0, 1'b1, 1'b0, 1'b0);

    // Flush from SKID with a live incoming entry that must be dropped
    cycle(1'b1, 32'h11110001, rc(), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h11110002, rc(), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hABCDE123, rc(), 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 32'd0, '0, 1'b1, 1'b0, 1'b0);
    check("flush_out_valid", OUT_VALID, 64'd0);
    check("flush_out_ctrl", OUT_CTRL, 64'd0);
    check("flush_in_ready", IN_READY, 64'd1);
`ifdef PIPE_PERF_CNT_EN
    check("flush_cnt_one", FLUSH_CNT, 64'd1);
`endif
    repeat (2) cycle(1'b0, 32'd0, '0, 1'b1, 1'b0, 1'b0);
    check("flushed_never_seen", 64'(seen_bad), 64'd0);

    // Asynchronous reset between edges while in SKID
    cycle(1'b1, 32'h22220001, rc(), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h22220002, rc(), 1'b0, 1'b0, 1'b0);
    @(posedge CLK);
    #2;
    check("pre_async_skid", IN_READY, 64'd0);
    RESET = 1'b1;
    IN_VALID = 1'b0;
    #1;
    check("async_out_valid", OUT_VALID, 64'd0);
    check("async_out_ctrl", OUT_CTRL, 64'd0);
    check("async_in_ready", IN_READY, 64'd0);
    check("async_stall_cnt", STALL_CNT, 64'd0);
    check("async_flush_cnt", FLUSH_CNT, 64'd0);
    @(posedge CLK);
    #1 RESET = 1'b0;

    // BUSYWAIT for 3 cycles in FULL with OUT_READY=1
    cycle(1'b1, 32'h33330001, rc(), 1'b0, 1'b0, 1'b0);
    repeat (3) cycle(1'b1, 32'h33330002, rc(), 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 32'd0, '0, 1'b1, 1'b0, 1'b0);
`ifdef PIPE_PERF_CNT_EN
    check("busywait_stall_cnt", STALL_CNT, 64'd3);
`endif
    cycle(1'b0, 32'd0, '0, 1'b1, 1'b0, 1'b0);
    check("busywait_released", OUT_VALID, 64'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 9) < 7), $urandom, rc(), ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0));
    end
    repeat (3) cycle(1'b0, 32'd0, '0, 1'b1, 1'b0, 1'b0);

    // Counter saturation: one entry held for 20 cycles
    do_reset();
    cycle(1'b1, 32'h44440001, rc(), 1'b0, 1'b0, 1'b0);
    repeat (20) cycle(1'b0, 32'd0, '0, 1'b0, 1'b0, 1'b0);
`ifdef PIPE_PERF_CNT_EN
    check("stall_saturated", STALL_CNT, 64'hF);
`else
    check("stall_tied_off", STALL_CNT, 64'd0);
`endif
    repeat (2) cycle(1'b0, 32'd0, '0, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
